// File: rtl/decode_iqueue.sv
// decode_iqueue: DEPTH-entry fetch-to-decode FIFO of {hit, predBJ, pc, instr} records
// Ports: clk/reset (async, active-high); fetch side push_F, buffIn_D, full_F;
// decode side stall_D, flush_DF, mispred_D and head outputs valid_D, count_D,
// hit_D, predBJ_D, pc_D, instr_D, rs_D/rt_D/rd_D; ovf_D pulses after a dropped push.
module decode_iqueue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_F,
  input  logic [2*WIDTH+1:0] buffIn_D,
  input  logic               stall_D,
  input  logic               flush_DF,
  input  logic               mispred_D,
  output logic               full_F,
  output logic               valid_D,
  output logic [CNTW-1:0]    count_D,
  output logic               hit_D,
  output logic               predBJ_D,
  output logic [WIDTH-1:0]   pc_D,
  output logic [WIDTH-1:0]   instr_D,
  output logic [4:0]         rs_D,
  output logic [4:0]         rt_D,
  output logic [4:0]         rd_D,
  output logic               ovf_D
);
  localparam int RW = 2*WIDTH+2;
  localparam int PW = $clog2(DEPTH);
  logic [RW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            pop, push_ok, we, misp;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction
  assign valid_D = cnt_q != '0;
  assign full_F  = cnt_q == CNTW'(DEPTH);
  assign count_D = cnt_q;
  assign ovf_D   = ovf_q;
  assign pop     = valid_D & ~stall_D;
  assign push_ok = push_F & (~full_F | pop);
  assign misp    = mispred_D & valid_D & ~flush_DF;
  // empty queue presents an all-zero record so decode sees a NOP bubble
  assign {hit_D, predBJ_D, pc_D, instr_D} = valid_D ? mem_q[rd_q] : '0;
  assign rs_D = instr_D[25:21];
  assign rt_D = instr_D[20:16];
  assign rd_D = instr_D[15:11];
  always_comb begin
    we    = ~flush_DF & ~misp & push_ok;
    ovf_d = ~flush_DF & ~misp & push_F & full_F & ~pop;
    rd_d  = flush_DF ? '0 : (pop ? inc(rd_q) : rd_q);
    // a mispredict keeps at most the head, so the write slot restarts just past it
    wr_d  = flush_DF ? '0 : misp ? inc(rd_q) : (push_ok ? inc(wr_q) : wr_q);
    cnt_d = flush_DF ? '0 : misp ? CNTW'(stall_D) : cnt_q + CNTW'(push_ok) - CNTW'(pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  always_ff @(posedge clk)
    if (we) mem_q[wr_q] <= buffIn_D;
endmodule

// File: tb/tb_decode_iqueue.sv
// tb_decode_iqueue: scoreboard bench for decode_iqueue against a queue-based reference model
module tb_decode_iqueue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH+1);
  localparam int RW    = 2*WIDTH+2;
  typedef struct {
    bit          v;
    bit          f;
    bit          ovf;
    int          cnt;
    logic [RW-1:0] head;
  } exp_t;
  logic clk = 0, reset = 1, push_F = 0, stall_D = 0, flush_DF = 0, mispred_D = 0;
  logic [RW-1:0] buffIn_D = '0;
  logic full_F, valid_D, hit_D, predBJ_D, ovf_D;
  logic [CNTW-1:0] count_D;
  logic [WIDTH-1:0] pc_D, instr_D;
  logic [4:0] rs_D, rt_D, rd_D;
  int checks = 0, errors = 0;
  logic [RW-1:0] mq[$];
  bit ovf_m = 0;
  exp_t sbq[$];
  decode_iqueue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push_F(push_F), .buffIn_D(buffIn_D), .stall_D(stall_D),
    .flush_DF(flush_DF), .mispred_D(mispred_D), .full_F(full_F), .valid_D(valid_D),
    .count_D(count_D), .hit_D(hit_D), .predBJ_D(predBJ_D), .pc_D(pc_D), .instr_D(instr_D),
    .rs_D(rs_D), .rt_D(rt_D), .rd_D(rd_D), .ovf_D(ovf_D)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [RW-1:0] mk(input logic [31:0] pc, input logic [31:0] ins);
    logic [1:0] hb;
    hb = 2'($urandom_range(0, 3));
    return {hb, pc, ins};
  endfunction
  always @(negedge clk)
    if (sbq.size() != 0) begin
      exp_t e;
      logic [WIDTH-1:0] ei;
      e  = sbq.pop_front();
      ei = e.head[WIDTH-1:0];
      chk("valid", RW'(valid_D), RW'(e.v));
      chk("full", RW'(full_F), RW'(e.f));
      chk("count", RW'(count_D), RW'(e.cnt));
      chk("ovf", RW'(ovf_D), RW'(e.ovf));
      chk("head", {hit_D, predBJ_D, pc_D, instr_D}, e.head);
      if (e.v) chk("regs", RW'({rs_D, rt_D, rd_D}), RW'({ei[25:21], ei[20:16], ei[15:11]}));
    end
  task automatic step(input bit p, input logic [RW-1:0] r, input bit s, input bit fl, input bit mp);
    exp_t e;
    bit v, f, pp;
    @(posedge clk);
    #1;
    push_F = p; buffIn_D = r; stall_D = s; flush_DF = fl; mispred_D = mp;
    v = mq.size() != 0;
    f = mq.size() == DEPTH;
    e.v = v; e.f = f; e.ovf = ovf_m; e.cnt = mq.size(); e.head = v ? mq[0] : '0;
    sbq.push_back(e);
    pp = v & ~s;
    if (fl) begin
      mq.delete();
      ovf_m = 0;
    end else if (mp && v) begin
      logic [RW-1:0] h;
      h = mq[0];
      mq.delete();
      if (s) mq.push_back(h);
      ovf_m = 0;
    end else begin
      ovf_m = p & f & ~pp;
      if (pp) void'(mq.pop_front());
      if (p && (!f || pp)) mq.push_back(r);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", RW'(valid_D), '0);
    chk("rst_count", RW'(count_D), '0);
    chk("rst_full", RW'(full_F), '0);
    reset = 0;
    for (int i = 0; i < 4; i++) step(1, mk(32'h100 + 4*i, $urandom), 1, 0, 0);
    step(1, mk(32'h110, $urandom), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, mk(32'h100 + 4*i, $urandom), 1, 0, 0);
    for (int i = 0; i < 3*DEPTH; i++) step(1, mk(32'h110 + 4*i, $urandom), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 0);
    step(1, {2'b10, 32'h400, 32'h012A4020}, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    #3;
    chk("lat_rs", RW'(rs_D), RW'(9));
    chk("lat_rt", RW'(rt_D), RW'(10));
    chk("lat_rd", RW'(rd_D), RW'(8));
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, mk(32'h500 + 4*i, $urandom), 1, 0, 0);
    step(1, mk(32'h600, $urandom), 1, 1, 1);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, mk(32'h200 + 4*i, $urandom), 1, 0, 0);
    step(1, mk(32'h700, $urandom), 1, 0, 1);
    step(0, '0, 1, 0, 0);
    #3;
    chk("misp_pc", RW'(pc_D), RW'(32'h200));
    step(1, mk(32'h704, $urandom), 0, 0, 1);
    step(1, mk(32'h300, $urandom), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    #3;
    chk("misp_next", RW'(pc_D), RW'(32'h300));
    step(0, '0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, mk(32'h800 + 4*i, $urandom), 1, 0, 0);
    step(0, '0, 1, 0, 0);
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("arst_valid", RW'(valid_D), '0);
    chk("arst_count", RW'(count_D), '0);
    chk("arst_instr", RW'(instr_D), '0);
    mq.delete();
    ovf_m = 0;
    reset = 0;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 9) < 7, mk($urandom, $urandom), $urandom_range(0, 9) < 4,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
    step(0, '0, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
